shift32_iter: RTL and testbench
===============================

# shift32_iter

Iterative, multi-cycle 32-bit shift unit executing the same command set as the combinational `shift32`: `sll`, `srl` and `sra` strobes with `in` and `shamt`. It accepts a command with a strobe/busy handshake and shifts by up to STEP bits per cycle. It reports completion with a one-cycle `done` pulse. It sits where a small-area datapath replaces the barrel shifter, and is verified against the same `test_shift32.pat` vectors (`fun` field: 100=sll, 010=srl, 001=sra).

## Interface
- STEP, 1, bits shifted per cycle; legal values 1, 2, 4, 8.
- m_clock  in  1  clock; all state changes on the rising edge.
- p_reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- sll  in  1  command strobe: shift left logical.
- srl  in  1  command strobe: shift right logical.
- sra  in  1  command strobe: shift right arithmetic.
- in  in  32  operand; sampled on the acceptance edge.
- shamt  in  5  shift amount 0..31; sampled on the acceptance edge.
- out  out  32  result; valid when `done`=1, held until the next `done`.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse; result is present on `out`.
- err  out  1  one-cycle pulse; strobe combination illegal while idle.

## Operation
- States:
  - IDLE.
  - RUN.
- Registers:
  - data[31:0]: working value.
  - rem[4:0]: remaining shift count.
  - op: command, one-hot, 3 bits.
  - sign: in[31], latched at acceptance.
- IDLE behaviour:
  - Exactly one strobe high at an edge: accept the command. data←in, rem←shamt, op←strobe, sign←in[31], busy←1, state→RUN.
  - Two or more strobes high: no acceptance; err pulses 1 for the following cycle; state stays IDLE.
  - No strobe: stay in IDLE.
- RUN behaviour, each edge:
  - k = min(rem, STEP). Shift data by k; rem←rem−k.
  - Fill bits: sll inserts 0 at the LSB; srl inserts 0 at the MSB; sra inserts `sign` at the MSB.
  - If rem ≤ STEP before the edge, this is the final step: out←shifted data, done←1, busy←0, state→IDLE.
- Strobes during RUN are ignored. They are neither queued nor flagged by err.
- shamt=0 still occupies one RUN cycle; out=in.
- Results are bit-exact with `shift32` for all 32-bit in and 0..31 shamt.

## Timing
- Reset values:
  - out=0, busy=0, done=0, err=0.
  - state=IDLE, data=0, rem=0.
- Reset mid-operation aborts the command immediately (asynchronous). No done pulse is produced for the aborted command.
- Latency: done is high in the cycle after edge N, where N = max(1, ceil(shamt/STEP)) edges after the acceptance edge.
  - STEP=1, shamt=31: done 31 cycles after acceptance.
  - STEP=8, shamt=17: done 3 cycles after acceptance.
- busy is high from the acceptance edge through the cycle before done. It is low in the cycle where done is high.
- Back-to-back commands:
  - A strobe present in the done cycle is accepted at the next edge (state is IDLE then).
  - Throughput is therefore N+1 cycles per command.
- done and err are never high in the same cycle.

## Structure
- Shared package `shift_pkg`:
  - Op encodings OP_SLL=3'b100, OP_SRL=3'b010, OP_SRA=3'b001, matching the pattern `fun` field.
  - State encoding IDLE/RUN.
  - Function `step_ok(STEP)` for the parameter legality check.
- One sub-module, `shift_step`: combinational shift of 32 bits by k∈[0,STEP], with op and sign inputs. The top level holds the FSM, counter and output registers.

## Test plan
- sll, in=0x00000001, shamt=31, STEP=1 -> busy for 31 cycles, done once, out=0x80000000.
- sra, in=0x80000000, shamt=4 -> out=0xF8000000; srl with the same operands -> out=0x08000000; each done 4 cycles after acceptance.
- srl, in=0x12345678, shamt=0 -> done 1 cycle after acceptance, out=0x12345678.
- sll+sra high together while idle -> err pulse 1 cycle, busy stays 0, out unchanged; sll strobed again while busy -> ignored, single done.
- p_reset=0 midway through sll shamt=20 -> out/busy/done/err=0 at once, no done pulse; a new command after release completes correctly.
- STEP=8, sra, in=0x87654321, shamt=17 -> done 3 cycles after acceptance, out=0xFFFFC3B2; all 128 entries of test_shift32.pat replayed -> every out matches shift32.

Source files
------------

// File: rtl/shift32_iter_pkg.sv
`default_nettype none
// ============================================================================
// Package : shift_pkg -- op encodings, FSM states and STEP legality helper
// Rev     : 1.0
// ============================================================================
package shift_pkg;

    // One-hot op codes line up with the {sll, srl, sra} strobe order
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b010;
    localparam logic [2:0] OP_SRA = 3'b001;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic step_ok(input int step);
        return (step == 1) || (step == 2) || (step == 4) || (step == 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift32_iter_if.sv
`default_nettype none
// ============================================================================
// Interface : shift32_iter_if -- command strobes, operands and result/status
// Rev       : 1.0
// ============================================================================
interface shift32_iter_if;
    logic        sll;
    logic        srl;
    logic        sra;
    logic [31:0] in;
    logic [4:0]  shamt;
    logic [31:0] out;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output sll, srl, sra, in, shamt,
        input  out, busy, done, err
    );

    modport slave (
        input  sll, srl, sra, in, shamt,
        output out, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/shift32_iter_step.sv
`default_nettype none
// ============================================================================
// Module : shift_step -- combinational 32-bit shift by k in [0, STEP]
// Rev    : 1.0
// ============================================================================
module shift_step
    import shift_pkg::*;
#(
    parameter  int STEP = 1,
    localparam int K_W  = $clog2(STEP + 1)
) (
    input  wire logic [31:0]    i_data,
    input  wire logic [K_W-1:0] i_k,
    input  wire logic [2:0]     i_op,
    input  wire logic           i_sign,
    output logic      [31:0]    o_data
);

    logic [31:0] w_fill_mask;

    // Bits vacated at the MSB by a right shift of k
    assign w_fill_mask = ~(32'hFFFF_FFFF >> i_k);

    always_comb begin
        o_data = i_data;
        case (i_op)
            OP_SLL:  o_data = i_data << i_k;
            OP_SRL:  o_data = i_data >> i_k;
            OP_SRA:  o_data = (i_data >> i_k) | (w_fill_mask & {32{i_sign}});
            default: o_data = i_data;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/shift32_iter.sv
`default_nettype none
// ============================================================================
// Module : shift32_iter -- iterative 32-bit shifter, up to STEP bits per cycle
// Rev    : 1.0
// ============================================================================
module shift32_iter
    import shift_pkg::*;
#(
    parameter int STEP = 1
) (
    input  wire logic     m_clock,
    input  wire logic     p_reset,
    shift32_iter_if.slave bus
);

    localparam int             K_W        = $clog2(STEP + 1);
    localparam logic [4:0]     C_STEP_REM = 5'(STEP);
    localparam logic [K_W-1:0] C_STEP_K   = K_W'(STEP);

    generate
        if (!step_ok(STEP)) begin : g_step_check
            $error("shift32_iter: STEP must be 1, 2, 4 or 8");
        end
    endgenerate

    state_t      state_q, state_d;
    logic [31:0] data_q,  data_d;
    logic [4:0]  rem_q,   rem_d;
    logic [2:0]  op_q,    op_d;
    logic        sign_q,  sign_d;
    logic [31:0] out_q,   out_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;
    logic        err_q,   err_d;

    logic [2:0]     w_strobe;
    logic           w_one_hot;
    logic           w_final;
    logic [K_W-1:0] w_k;
    logic [31:0]    w_step_data;

    assign w_strobe  = {bus.sll, bus.srl, bus.sra};
    assign w_one_hot = (w_strobe != 3'b000) && ((w_strobe & (w_strobe - 3'd1)) == 3'b000);

    // The last step consumes whatever remains, which always fits in K_W bits
    assign w_final = (rem_q <= C_STEP_REM);
    assign w_k     = w_final ? rem_q[K_W-1:0] : C_STEP_K;

    shift_step #(
        .STEP (STEP)
    ) u_step (
        .i_data (data_q),
        .i_k    (w_k),
        .i_op   (op_q),
        .i_sign (sign_q),
        .o_data (w_step_data)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        op_d    = op_q;
        sign_d  = sign_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_one_hot) begin
                    data_d  = bus.in;
                    rem_d   = bus.shamt;
                    op_d    = w_strobe;
                    sign_d  = bus.in[31];
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end else if (w_strobe != 3'b000) begin
                    err_d = 1'b1;
                end
            end
            ST_RUN: begin
                // Strobes are deliberately not looked at here
                data_d = w_step_data;
                rem_d  = rem_q - 5'(w_k);
                if (w_final) begin
                    out_d   = w_step_data;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            state_q <= ST_IDLE;
            data_q  <= 32'd0;
            rem_q   <= 5'd0;
            op_q    <= 3'b000;
            sign_q  <= 1'b0;
            out_q   <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            sign_q  <= sign_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_shift32_iter.sv
`default_nettype none
// ============================================================================
// Module : tb_shift32_iter -- STEP=1 and STEP=8 instances driven in lockstep
// Rev    : 1.0
// ============================================================================
module tb_shift32_iter;
    import shift_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    shift32_iter_if if1 ();
    shift32_iter_if if8 ();

    shift32_iter #(.STEP(1)) dut1 (.m_clock(clk), .p_reset(rst_n), .bus(if1));
    shift32_iter #(.STEP(8)) dut8 (.m_clock(clk), .p_reset(rst_n), .bus(if8));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] din;
        logic [4:0]  sh;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] d, input logic [4:0] sh);
        {if1.sll, if1.srl, if1.sra} = op;
        {if8.sll, if8.srl, if8.sra} = op;
        if1.in = d;  if1.shamt = sh;
        if8.in = d;  if8.shamt = sh;
    endtask

    // Reference result straight from the shift definitions
    function automatic logic [31:0] ref_shift(input logic [2:0] op, input logic [31:0] d,
                                              input logic [4:0] sh);
        logic signed [31:0] s;
        s = d;
        case (op)
            OP_SLL:  return d << sh;
            OP_SRL:  return d >> sh;
            default: return s >>> sh;
        endcase
    endfunction

    function automatic int lat(input int step, input int sh);
        return (sh == 0) ? 1 : (sh + step - 1) / step;
    endfunction

    // Issue one legal command, optionally re-strobing while busy, and check both instances
    task automatic run_cmd(input string name, input logic [2:0] op, input logic [31:0] d,
                           input logic [4:0] sh, input logic [31:0] exp, input bit poke);
        int          n [2];
        int          done_c [2];
        int          done_n [2];
        int          busy_bad [2];
        int          err_n;
        logic [31:0] outv [2];
        n[0] = lat(1, int'(sh));
        n[1] = lat(8, int'(sh));
        err_n = 0;
        for (int i = 0; i < 2; i++) begin
            done_c[i] = -1; done_n[i] = 0; busy_bad[i] = 0; outv[i] = 32'hx;
        end
        @(negedge clk);
        drive(op, d, sh);
        for (int c = 0; c < n[0] + 3; c++) begin
            @(negedge clk);
            if (if1.done) begin
                done_n[0]++;
                if (done_c[0] < 0) begin done_c[0] = c; outv[0] = if1.out; end
            end
            if (if8.done) begin
                done_n[1]++;
                if (done_c[1] < 0) begin done_c[1] = c; outv[1] = if8.out; end
            end
            if ((c < n[0]) != if1.busy) busy_bad[0]++;
            if ((c < n[1]) != if8.busy) busy_bad[1]++;
            if (if1.err || if8.err) err_n++;
            if (c == 0) drive(poke ? op : 3'b000, ~d, sh);
            if (c == 1) drive(3'b000, 32'd0, 5'd0);
        end
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_s%0d_out", name, i ? 8 : 1), outv[i], exp);
            check($sformatf("%s_s%0d_latency", name, i ? 8 : 1), done_c[i], n[i]);
            check($sformatf("%s_s%0d_done_count", name, i ? 8 : 1), done_n[i], 1);
            check($sformatf("%s_s%0d_busy_shape", name, i ? 8 : 1), busy_bad[i], 0);
        end
        check($sformatf("%s_no_err", name), err_n, 0);
    endtask

    initial begin
        logic [31:0] p1, p8;
        logic [2:0]  rop;
        logic [31:0] rd;
        logic [4:0]  rsh;
        int          seen;

        vecs[0]  = '{OP_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000};
        vecs[1]  = '{OP_SRA, 32'h8000_0000, 5'd4,  32'hF800_0000};
        vecs[2]  = '{OP_SRL, 32'h8000_0000, 5'd4,  32'h0800_0000};
        vecs[3]  = '{OP_SRL, 32'h1234_5678, 5'd0,  32'h1234_5678};
        vecs[4]  = '{OP_SRA, 32'h8765_4321, 5'd17, 32'hFFFF_C3B2};
        vecs[5]  = '{OP_SLL, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FF00};
        vecs[6]  = '{OP_SRL, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001};
        vecs[7]  = '{OP_SRA, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000};
        vecs[8]  = '{OP_SRA, 32'hFFFF_FFFF, 5'd31, 32'hFFFF_FFFF};
        vecs[9]  = '{OP_SLL, 32'hA5A5_A5A5, 5'd4,  32'h5A5A_5A50};
        vecs[10] = '{OP_SRL, 32'hA5A5_A5A5, 5'd9,  32'h0052_D2D2};
        vecs[11] = '{OP_SRA, 32'h8000_0001, 5'd1,  32'hC000_0000};

        rst_n = 1'b0;
        drive(3'b000, 32'd0, 5'd0);
        repeat (3) @(negedge clk);
        check("rst_out_s1", if1.out, 32'd0);
        check("rst_out_s8", if8.out, 32'd0);
        check("rst_flags_s1", {if1.busy, if1.done, if1.err}, 32'd0);
        check("rst_flags_s8", {if8.busy, if8.done, if8.err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_flags", {if1.busy, if1.done, if1.err, if8.busy, if8.done, if8.err}, 32'd0);

        for (int i = 0; i < 12; i++)
            run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].din, vecs[i].sh, vecs[i].exp, 1'b0);

        // Illegal strobe pair while idle
        p1 = if1.out;
        p8 = if8.out;
        @(negedge clk);
        drive(OP_SLL | OP_SRA, 32'hDEAD_BEEF, 5'd3);
        @(negedge clk);
        check("illegal_err", {if1.err, if8.err}, 32'h3);
        check("illegal_busy", {if1.busy, if8.busy}, 32'h0);
        check("illegal_out_s1", if1.out, p1);
        check("illegal_out_s8", if8.out, p8);
        drive(3'b000, 32'd0, 5'd0);
        @(negedge clk);
        check("illegal_err_pulse", {if1.err, if8.err, if1.busy, if8.busy}, 32'h0);

        // Strobe while busy is ignored
        run_cmd("ignore", OP_SLL, 32'h0000_0001, 5'd10, 32'h0000_0400, 1'b1);

        // Back-to-back: next command sits on the strobes during the done cycle
        @(negedge clk);
        drive(OP_SRA, 32'h8000_0000, 5'd0);
        @(negedge clk);
        check("b2b_busy0", {if1.busy, if8.busy}, 32'h3);
        drive(3'b000, 32'd0, 5'd0);
        @(negedge clk);
        check("b2b_done1", {if1.done, if8.done}, 32'h3);
        check("b2b_out1", if1.out ^ if8.out ^ 32'h8000_0000, 32'h8000_0000);
        drive(OP_SRL, 32'hCAFE_F00D, 5'd0);
        @(negedge clk);
        check("b2b_busy2", {if1.busy, if8.busy, if1.done, if8.done}, 32'hC);
        drive(3'b000, 32'd0, 5'd0);
        @(negedge clk);
        check("b2b_done3", {if1.done, if8.done}, 32'h3);
        check("b2b_out3_s1", if1.out, 32'hCAFE_F00D);
        check("b2b_out3_s8", if8.out, 32'hCAFE_F00D);

        // Asynchronous reset mid-command
        @(negedge clk);
        drive(OP_SLL, 32'h0000_0003, 5'd20);
        @(negedge clk);
        drive(3'b000, 32'd0, 5'd0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_out_s1", if1.out, 32'd0);
        check("abort_out_s8", if8.out, 32'd0);
        check("abort_flags", {if1.busy, if1.done, if1.err, if8.busy, if8.done, if8.err}, 32'd0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (if1.done || if8.done) seen++;
        end
        rst_n = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (if1.done || if8.done || if1.busy || if8.busy) seen++;
        end
        check("abort_no_done", seen, 0);
        run_cmd("post_rst", OP_SRL, 32'hF000_000F, 5'd4, 32'h0F00_0000, 1'b0);

        // Randomised commands against the reference model
        for (int i = 0; i < 128; i++) begin
            case ($urandom_range(0, 2))
                0:       rop = OP_SLL;
                1:       rop = OP_SRL;
                default: rop = OP_SRA;
            endcase
            rd  = $urandom;
            rsh = 5'($urandom_range(0, 31));
            run_cmd($sformatf("rnd%0d", i), rop, rd, rsh, ref_shift(rop, rd, rsh),
                    1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
